// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL manager backed by a word-addressed SRAM, returning in-order D responses after a fixed latency.
// Define TL_MEM_TRACE_EN to print every A accept and D handshake (simulation only).
module tl_ul_mem_responder #(
  parameter int unsigned MEM_WORDS    = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter int unsigned SOURCE_WIDTH = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [2:0]              a_bits_opcode,
  input  logic [3:0]              a_bits_size,
  input  logic [SOURCE_WIDTH-1:0] a_bits_source,
  input  logic [31:0]             a_bits_address,
  input  logic [3:0]              a_bits_mask,
  input  logic [31:0]             a_bits_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [2:0]              d_bits_opcode,
  output logic [3:0]              d_bits_size,
  output logic [SOURCE_WIDTH-1:0] d_bits_source,
  output logic [31:0]             d_bits_data,
  output logic                    d_bits_denied
);

  localparam int unsigned   AW         = $clog2(MEM_WORDS);
  localparam int unsigned   PW         = $clog2(QUEUE_DEPTH);
  localparam int unsigned   CW         = PW + 1;
  localparam logic [32:0]   MEM_BYTES  = 33'(MEM_WORDS) * 33'd4;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);
  localparam logic [3:0]    TIMER_INIT = 4'(LATENCY - 1);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  logic [31:0] mem [MEM_WORDS];

  logic [2:0]              q_opcode [QUEUE_DEPTH];
  logic [3:0]              q_size   [QUEUE_DEPTH];
  logic [SOURCE_WIDTH-1:0] q_source [QUEUE_DEPTH];
  logic [31:0]             q_data   [QUEUE_DEPTH];
  logic                    q_denied [QUEUE_DEPTH];
  logic [3:0]              q_timer  [QUEUE_DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [31:0]   offset;
  logic          in_range;
  logic          is_put;
  logic          is_get;
  logic          req_denied;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_data;
  logic [2:0]    resp_opcode;
  logic [31:0]   resp_data;
  logic          accept;
  logic          dequeue;

  always_comb begin
    offset      = a_bits_address - BASE_ADDR;
    in_range    = {1'b0, offset} < MEM_BYTES;
    word_idx    = offset[AW+1:2];
    is_put      = (a_bits_opcode == OP_PUT_FULL) || (a_bits_opcode == OP_PUT_PARTIAL);
    is_get      = (a_bits_opcode == OP_GET);
    req_denied  = !in_range || !(is_put || is_get);
    rd_data     = mem[word_idx];
    resp_opcode = is_get ? OP_ACK_DATA : OP_ACK;
    resp_data   = (is_get && !req_denied) ? rd_data : 32'd0;
  end

  // Readiness depends only on occupancy, never on d_ready, so no A-to-D combinational path exists.
  assign a_ready = !reset && (count < FULL_COUNT);
  assign accept  = a_valid && a_ready;
  assign d_valid = !reset && (count != '0) && (q_timer[head] == 4'd0);
  assign dequeue = d_valid && d_ready;

  // Backing store is intentionally never reset so data survives a mid-run reset.
  always_ff @(posedge clock) begin
    if (accept && is_put && !req_denied) begin
      for (int i = 0; i < 4; i++) begin
        if (a_bits_mask[i]) begin
          mem[word_idx][8*i +: 8] <= a_bits_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (accept && (tail == PW'(i))) begin
        q_opcode[i] <= resp_opcode;
        q_size[i]   <= a_bits_size;
        q_source[i] <= a_bits_source;
        q_data[i]   <= resp_data;
        q_denied[i] <= req_denied;
        q_timer[i]  <= TIMER_INIT;
      end else if (q_timer[i] != 4'd0) begin
        q_timer[i] <= q_timer[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        tail <= tail + PW'(1);
      end
      if (dequeue) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(accept) - CW'(dequeue);
    end
  end

  // Payload is forced to zero whenever no response is being offered.
  always_comb begin
    d_bits_opcode = '0;
    d_bits_size   = '0;
    d_bits_source = '0;
    d_bits_data   = '0;
    d_bits_denied = 1'b0;
    if (d_valid) begin
      d_bits_opcode = q_opcode[head];
      d_bits_size   = q_size[head];
      d_bits_source = q_source[head];
      d_bits_data   = q_data[head];
      d_bits_denied = q_denied[head];
    end
  end

`ifdef TL_MEM_TRACE_EN
  always_ff @(posedge clock) begin
    if (accept) begin
      if (is_put) begin
        $display("[%0t] tl_mem A op=%0d src=%0d addr=%h mask=%h wdata=%h denied=%0b",
                 $time, a_bits_opcode, a_bits_source, a_bits_address, a_bits_mask, a_bits_data, req_denied);
      end else begin
        $display("[%0t] tl_mem A op=%0d src=%0d addr=%h mask=%h rdata=%h denied=%0b",
                 $time, a_bits_opcode, a_bits_source, a_bits_address, a_bits_mask, resp_data, req_denied);
      end
    end
    if (dequeue) begin
      $display("[%0t] tl_mem D src=%0d op=%0d", $time, d_bits_source, d_bits_opcode);
    end
  end
`else
  // Trace printing compiled out; logic is identical.
`endif

endmodule

// File: doc/tl_ul_mem_responder.md
Name: tl_ul_mem_responder

Overview:
- Single-lane TileLink-UL responder (manager side) that terminates one `imem_N` or `dmem_N` lane driven by the Vortex core adapter.
- Accepts Get, PutFullData and PutPartialData on channel A; backs them with a word-addressed behavioural SRAM.
- Returns AccessAckData or AccessAck on channel D after a fixed, parameterised latency, with a bounded in-order response queue.
- Instantiated once per lane (1 imem + 4 dmem) in the standalone core testbench.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words in backing store (power of 2).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from A handshake to earliest D valid; legal range 1..15.
- QUEUE_DEPTH, 4, max outstanding responses; power of 2, at least 2.
- SOURCE_WIDTH, 10, width of source field.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  channel A valid
- a_ready  out  1  channel A ready
- a_bits_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
- a_bits_size  in  4  log2 bytes; echoed on D
- a_bits_source  in  SOURCE_WIDTH  request id
- a_bits_address  in  32  byte address
- a_bits_mask  in  4  byte enables
- a_bits_data  in  32  write data
- d_valid  out  1  channel D valid
- d_ready  in  1  channel D ready
- d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_bits_size  out  4  echo of a_bits_size
- d_bits_source  out  SOURCE_WIDTH  echo of a_bits_source
- d_bits_data  out  32  read data; 0 for AccessAck
- d_bits_denied  out  1  error response

Behaviour:
- Reset:
  - Queue emptied; count=0.
  - d_valid=0; d_bits_* all 0.
  - a_ready=1 from the first cycle after reset deasserts; a_ready=0 while reset is high.
  - SRAM contents are not reset: writes accepted before a mid-operation reset persist, and pending responses are discarded.
- Channel A handshake:
  - Accept when a_valid && a_ready.
  - a_ready = (count < QUEUE_DEPTH). It does not depend on d_ready, so there is no A-to-D combinational path.
  - When full, no request is accepted even if a dequeue happens in the same cycle.
- Address decode:
  - offset = address - BASE_ADDR.
  - In range iff offset < MEM_WORDS*4.
  - Word index = offset[log2(MEM_WORDS)+1:2]; address[1:0] ignored.
- Memory effect, applied at the accept edge:
  - PutFull/PutPartial, in range: write bytes where mask[i]=1. Mask 0 means no change.
  - Get, in range: read word captured into the queue entry at the same edge. It reflects all earlier accepted writes (strict program order).
  - Out of range, or opcode not in {0,1,4}: no memory effect; denied=1; data=0.
- Response opcode:
  - Get yields 1 (AccessAckData); Put yields 0 (AccessAck).
  - An unsupported opcode yields 0 with denied=1.
- Queue entry fields: opcode, size, source, data, denied, 4-bit timer.
  - Timer is loaded with LATENCY-1 at accept and decrements by 1 each later cycle, saturating at 0. All entries age in parallel.
- Channel D:
  - d_valid = (count != 0) && (head.timer == 0).
  - A request accepted in cycle N produces d_valid no earlier than cycle N+LATENCY.
  - Responses are strictly in acceptance order.
- Back-pressure: once d_valid=1, d_bits_* hold stable until d_ready. Dequeue on d_valid && d_ready.
- Simultaneous enqueue and dequeue when not full: count unchanged; head and tail pointers both advance.
- Pointer arithmetic: log2(QUEUE_DEPTH)-bit pointers wrap modulo QUEUE_DEPTH; count is log2(QUEUE_DEPTH)+1 bits.
- Throughput: with d_ready=1 held, one response per cycle sustained once the pipeline fills (QUEUE_DEPTH >= LATENCY+1 needed for full rate).

Optional Feature:
- Macro: TL_MEM_TRACE_EN.
- Defined (simulation only):
  - Each accepted A beat prints time, opcode, source, address, mask and data (write) or read data, plus denied status.
  - Each D handshake prints time, source and opcode.
- Undefined: no $display statements and identical synthesisable logic.
- Port list and timing are unchanged either way.

Test Plan:
- Reset, then PutFull addr=0x8000_0010 data=0xDEADBEEF mask=0xF src=5 at cycle 10, d_ready=1 -> d_valid in cycle 12 (LATENCY=2) with opcode=0, source=5, denied=0.
- Then Get addr=0x8000_0010 src=7 -> AccessAckData with data=0xDEADBEEF, source=7. Then PutPartial mask=0x3 data=0x00001234 to the same address, then Get -> data=0xDEAD1234.
- Issue 4 back-to-back Gets (src 1..4) with d_ready=0 -> a_ready=0 from the cycle after the 4th accept. Raise d_ready -> responses arrive in order 1,2,3,4, one per cycle; a_ready returns to 1 the cycle after the first dequeue.
- Get to 0x0000_1000 (out of range) src=9 -> opcode=1, denied=1, data=0. Opcode 3 at a valid address -> opcode=0, denied=1, memory unchanged.
- Put accepted, reset asserted for 1 cycle while its response is pending -> d_valid=0 after reset, no stale response. A subsequent Get returns the written data.
- Streaming 32 Gets with d_ready toggling pseudo-randomly -> every source returned exactly once, in order, d_bits stable while stalled, and no accept while count=QUEUE_DEPTH.
